// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the read arbiter, the register array and the read mux tree.
package regfile_pkg;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Read-client, read-mux, write-snoop and response signals of the shared register-file read path.
interface regfile_read_arbiter_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    import regfile_pkg::*;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ*REG_ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]            req_ready;
    logic                       stall;
    reg_addr_t                  mux_sel;
    reg_data_t                  mux_data;
    logic                       wr_en;
    reg_addr_t                  wr_addr;
    reg_data_t                  wr_data;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    reg_data_t                  rsp_data;

    modport slave (
        input  req_valid, req_addr, stall, mux_data, wr_en, wr_addr, wr_data,
        output req_ready, mux_sel, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_addr, stall, mux_data, wr_en, wr_addr, wr_data,
        input  req_ready, mux_sel, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/regfile_read_arbiter_rr.sv
// Round-robin picker: first request at or after ptr, wrapping; purely combinational.
// No backpressure of its own; a cleared req vector simply yields no grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);
    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read mux among NREQ clients; one grant per cycle, response registered (1 cycle).
// stall (or reset) suppresses grants; responses are never backpressured.
module regfile_read_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_read_arbiter_if.slave  bus
);
    logic [ID_W-1:0] rr_ptr;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic            any_grant;
    reg_addr_t       win_addr;
    reg_data_t       rd_data;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    reg_data_t       rsp_data_q;

    assign arb_req = (bus.stall || rst) ? '0 : bus.req_valid;

    rr_arbiter #(.N(NREQ), .IW(ID_W)) u_arb (
        .req       (arb_req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) win_addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        end
    end

    // A write landing this cycle is newer than what the mux sees, so it wins over mux_data.
    always_comb begin
        rd_data = bus.mux_data;
        if (ZERO_R0 && win_addr == '0)
            rd_data = '0;
        else if (bus.wr_en && bus.wr_addr == win_addr)
            rd_data = bus.wr_data;
    end

    assign bus.req_ready = grant;
    assign bus.mux_sel   = any_grant ? win_addr : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= any_grant;
            if (any_grant) begin
                rr_ptr     <= (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                rsp_id_q   <= grant_idx;
                rsp_data_q <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench: two arbiters (ZERO_R0=0/1) on shared stimulus, checked against a priority-distance model and register array.
module tb_regfile_read_arbiter;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_read_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) b ();
    regfile_read_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bz ();

    logic [31:0] regs [32];

    assign b.mux_data   = regs[b.mux_sel];
    assign bz.mux_data  = regs[bz.mux_sel];
    assign bz.req_valid = b.req_valid;
    assign bz.req_addr  = b.req_addr;
    assign bz.stall     = b.stall;
    assign bz.wr_en     = b.wr_en;
    assign bz.wr_addr   = b.wr_addr;
    assign bz.wr_data   = b.wr_data;

    regfile_read_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .ZERO_R0(1'b0)) dut (
        .clk (clk), .rst (rst), .bus (b.slave));
    regfile_read_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .ZERO_R0(1'b1)) dutz (
        .clk (clk), .rst (rst), .bus (bz.slave));

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [19:0] addr;
        logic        stall;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  exp_ready;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one cycle from a negedge, checks grant/select mid-cycle and the response after the edge.
    task automatic do_cycle(input logic [3:0] v, input logic [19:0] a, input logic st,
                            input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            output logic [3:0] rdy);
        int best, bestd, d;
        logic [3:0]  exp_rdy;
        logic [4:0]  exp_sel, ga;
        logic [31:0] ed, edz;
        b.req_valid = v; b.req_addr = a; b.stall = st;
        b.wr_en = we; b.wr_addr = wa; b.wr_data = wd;
        best = -1; bestd = NREQ; ga = '0; ed = '0; edz = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - mptr + NREQ) % NREQ;
            if (!st && v[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        exp_rdy = '0;
        exp_sel = '0;
        if (best >= 0) begin
            exp_rdy[best] = 1'b1;
            ga      = a[5*best +: 5];
            exp_sel = ga;
            ed      = (we && wa == ga) ? wd : regs[ga];
            edz     = (ga == 5'd0) ? 32'h0 : ed;
        end
        #2;
        rdy = b.req_ready;
        chk("req_ready", 32'(b.req_ready), 32'(exp_rdy));
        chk("mux_sel", 32'(b.mux_sel), 32'(exp_sel));
        @(posedge clk);
        #1;
        if (we) regs[wa] = wd;
        if (best >= 0) mptr = (best + 1) % NREQ;
        chk("rsp_valid", 32'(b.rsp_valid), 32'(best >= 0));
        chk("rsp_valid_z", 32'(bz.rsp_valid), 32'(best >= 0));
        if (best >= 0) begin
            chk("rsp_id", 32'(b.rsp_id), 32'(best));
            chk("rsp_data", b.rsp_data, ed);
            chk("rsp_data_z", bz.rsp_data, edz);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  rdy;
        logic [3:0]  rv;
        logic [19:0] ra;
        logic [4:0]  wa;

        for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | (i * 32'h111);
        regs[0] = 32'h55;
        regs[9] = 32'h1;

        vecs[0]  = '{4'hF, {5'd15, 5'd11, 5'd7, 5'd3}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b0001};
        vecs[1]  = '{4'hF, {5'd15, 5'd11, 5'd7, 5'd3}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b0010};
        vecs[2]  = '{4'hF, {5'd15, 5'd11, 5'd7, 5'd3}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b0100};
        vecs[3]  = '{4'hF, {5'd15, 5'd11, 5'd7, 5'd3}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b1000};
        vecs[4]  = '{4'hF, {5'd15, 5'd11, 5'd7, 5'd3}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b0001};
        vecs[5]  = '{4'hF, {5'd15, 5'd11, 5'd7, 5'd3}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b0010};
        vecs[6]  = '{4'hF, {5'd15, 5'd11, 5'd7, 5'd3}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b0100};
        vecs[7]  = '{4'hF, {5'd15, 5'd11, 5'd7, 5'd3}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b1000};
        vecs[8]  = '{4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 1'b0, 1'b1, 5'd9, 32'hDEADBEEF, 4'b0010};
        vecs[9]  = '{4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 1'b1, 1'b0, 5'd0, 32'h0, 4'b0000};
        vecs[10] = '{4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 1'b1, 1'b0, 5'd0, 32'h0, 4'b0000};
        vecs[11] = '{4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 1'b1, 1'b0, 5'd0, 32'h0, 4'b0000};
        vecs[12] = '{4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b0100};
        vecs[13] = '{4'b1000, {5'd13, 5'd0, 5'd0, 5'd0}, 1'b1, 1'b0, 5'd0, 32'h0, 4'b0000};
        vecs[14] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd4}, 1'b0, 1'b0, 5'd0, 32'h0, 4'b0001};
        vecs[15] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, 1'b1, 5'd0, 32'h77, 4'b0001};

        b.req_valid = 4'hF; b.req_addr = '0; b.stall = 1'b0;
        b.wr_en = 1'b0; b.wr_addr = '0; b.wr_data = '0;
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_req_ready", 32'(b.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(b.rsp_valid), 32'h0);
        chk("rst_rsp_data", b.rsp_data, 32'h0);
        chk("rst_rsp_id", 32'(b.rsp_id), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 16; t++) begin
            do_cycle(vecs[t].valid, vecs[t].addr, vecs[t].stall, vecs[t].we,
                     vecs[t].wa, vecs[t].wd, rdy);
            chk($sformatf("table_ready[%0d]", t), 32'(rdy), 32'(vecs[t].exp_ready));
        end

        // Response in flight, then an asynchronous reset pulse before the next edge.
        b.req_valid = 4'b0100; b.req_addr = {5'd0, 5'd6, 5'd0, 5'd0}; b.stall = 1'b0; b.wr_en = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_inflight", 32'(b.rsp_valid), 32'h1);
        b.req_valid = '0;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(b.rsp_valid), 32'h0);
        chk("midrst_rsp_data", b.rsp_data, 32'h0);
        rst = 1'b0;
        mptr = 0;
        @(posedge clk);
        #1;
        chk("midrst_after_edge", 32'(b.rsp_valid), 32'h0);
        @(negedge clk);
        do_cycle(4'b1010, {5'd2, 5'd0, 5'd8, 5'd0}, 1'b0, 1'b0, 5'd0, 32'h0, rdy);
        chk("post_rst_ptr", 32'(rdy), 32'h2);

        for (int n = 0; n < 400; n++) begin
            rv = 4'($urandom_range(15));
            for (int i = 0; i < NREQ; i++)
                ra[5*i +: 5] = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            wa = ($urandom_range(1) == 1) ? ra[5*$urandom_range(3) +: 5] : 5'($urandom_range(31));
            do_cycle(rv, ra, $urandom_range(3) == 0, $urandom_range(1) == 1, wa, $urandom, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
